// File: rtl/bf_program_loader.sv
// Brainfuck program loader: encodes ASCII commands to 4-bit opcodes, writes them to program memory,
// checks bracket balance, and appends HALT. Define LOADER_SYNC_EN to add 2-flop input synchronizers.
module bf_program_loader #(
    parameter int unsigned PM_DEPTH    = 1024,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DEPTH_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            charIn,
    input  logic                  charValid,
    input  logic                  loadDone,
    output logic [ADDR_WIDTH-1:0] pmAddress,
    output logic [3:0]            pmData,
    output logic                  pmWren,
    output logic                  PMInputDone,
    output logic [ADDR_WIDTH-1:0] instrCount,
    output logic                  error,
    output logic [1:0]            errCode
);

    typedef enum logic [1:0] {LOAD, TERM, DONE, ERR} stateT;

    localparam logic [3:0] OP_HALT  = 4'd0;
    localparam logic [3:0] OP_OPEN  = 4'd7;
    localparam logic [3:0] OP_CLOSE = 4'd8;
    localparam logic [ADDR_WIDTH-1:0] FULL_COUNT = ADDR_WIDTH'(PM_DEPTH - 1);

    stateT                  state, stateNext;
    logic [DEPTH_WIDTH-1:0] depth, depthNext;
    logic                   ldPending, pendNext;
    logic                   cvPrev, ldPrev;
    logic                   cvIn, ldIn;
    logic                   cvEdge, ldEdge;
    logic [3:0]             opcode;
    logic                   isCmd;

    logic [ADDR_WIDTH-1:0]  addrNext, countNext;
    logic [3:0]             dataNext;
    logic                   wrenNext, doneNext, errNext;
    logic [1:0]             codeNext;

`ifdef LOADER_SYNC_EN
    logic [1:0] cvSync, ldSync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cvSync <= '0;
            ldSync <= '0;
        end else begin
            cvSync <= {cvSync[0], charValid};
            ldSync <= {ldSync[0], loadDone};
        end
    end

    assign cvIn = cvSync[1];
    assign ldIn = ldSync[1];
`else
    assign cvIn = charValid;
    assign ldIn = loadDone;
`endif

    assign cvEdge = cvIn & ~cvPrev;
    assign ldEdge = ldIn & ~ldPrev;

    always_comb begin
        opcode = OP_HALT;
        isCmd  = 1'b1;
        case (charIn)
            8'h3E:   opcode = 4'd1;  // >
            8'h3C:   opcode = 4'd2;  // <
            8'h2B:   opcode = 4'd3;  // +
            8'h2D:   opcode = 4'd4;  // -
            8'h2E:   opcode = 4'd5;  // .
            8'h2C:   opcode = 4'd6;  // ,
            8'h5B:   opcode = OP_OPEN;
            8'h5D:   opcode = OP_CLOSE;
            default: isCmd  = 1'b0;
        endcase
    end

    always_comb begin
        stateNext = state;
        depthNext = depth;
        pendNext  = ldPending;
        addrNext  = pmAddress;
        dataNext  = pmData;
        wrenNext  = 1'b0;
        doneNext  = PMInputDone;
        countNext = instrCount;
        errNext   = error;
        codeNext  = errCode;

        case (state)
            LOAD: begin
                // A character edge wins the cycle; a coincident loadDone is deferred one cycle.
                if (cvEdge) begin
                    pendNext = ldPending | ldEdge;
                    if (isCmd) begin
                        if (opcode == OP_CLOSE && depth == '0) begin
                            stateNext = ERR;
                            errNext   = 1'b1;
                            codeNext  = 2'd1;
                        end else if (instrCount == FULL_COUNT ||
                                     (opcode == OP_OPEN && depth == '1)) begin
                            stateNext = ERR;
                            errNext   = 1'b1;
                            codeNext  = 2'd3;
                        end else begin
                            addrNext  = instrCount;
                            dataNext  = opcode;
                            wrenNext  = 1'b1;
                            countNext = instrCount + 1'b1;
                            if (opcode == OP_OPEN)
                                depthNext = depth + 1'b1;
                            else if (opcode == OP_CLOSE)
                                depthNext = depth - 1'b1;
                        end
                    end
                end else if (ldPending || ldEdge) begin
                    pendNext = 1'b0;
                    if (depth != '0) begin
                        stateNext = ERR;
                        errNext   = 1'b1;
                        codeNext  = 2'd2;
                    end else begin
                        stateNext = TERM;
                        addrNext  = instrCount;
                        dataNext  = OP_HALT;
                        wrenNext  = 1'b1;
                    end
                end
            end
            TERM: begin
                stateNext = DONE;
                doneNext  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= LOAD;
            depth       <= '0;
            ldPending   <= 1'b0;
            cvPrev      <= 1'b0;
            ldPrev      <= 1'b0;
            pmAddress   <= '0;
            pmData      <= '0;
            pmWren      <= 1'b0;
            PMInputDone <= 1'b0;
            instrCount  <= '0;
            error       <= 1'b0;
            errCode     <= '0;
        end else begin
            state       <= stateNext;
            depth       <= depthNext;
            ldPending   <= pendNext;
            cvPrev      <= cvIn;
            ldPrev      <= ldIn;
            pmAddress   <= addrNext;
            pmData      <= dataNext;
            pmWren      <= wrenNext;
            PMInputDone <= doneNext;
            instrCount  <= countNext;
            error       <= errNext;
            errCode     <= codeNext;
        end
    end

endmodule

// File: tb/tb_bf_program_loader.sv
// Directed bench for bf_program_loader: a default-depth instance and a PM_DEPTH=4 instance share inputs.
module tb_bf_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  charIn = '0;
    logic        charValid = 1'b0;
    logic        loadDone = 1'b0;

    logic [15:0] pmAddressA, instrCountA, pmAddressS, instrCountS;
    logic [3:0]  pmDataA, pmDataS;
    logic        pmWrenA, doneA, errorA, pmWrenS, doneS, errorS;
    logic [1:0]  errCodeA, errCodeS;

    int unsigned total = 0;
    int unsigned passed = 0;

    always #5 clock = ~clock;

    bf_program_loader dutA (
        .clock(clock), .reset(reset), .charIn(charIn), .charValid(charValid), .loadDone(loadDone),
        .pmAddress(pmAddressA), .pmData(pmDataA), .pmWren(pmWrenA), .PMInputDone(doneA),
        .instrCount(instrCountA), .error(errorA), .errCode(errCodeA)
    );

    bf_program_loader #(.PM_DEPTH(4)) dutS (
        .clock(clock), .reset(reset), .charIn(charIn), .charValid(charValid), .loadDone(loadDone),
        .pmAddress(pmAddressS), .pmData(pmDataS), .pmWren(pmWrenS), .PMInputDone(doneS),
        .instrCount(instrCountS), .error(errorS), .errCode(errCodeS)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b0;
        charValid = 1'b0;
        loadDone = 1'b0;
        charIn = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // One strobe held high for two cycles: expect at most one write, then nothing.
    task automatic strobe(input string tag, input logic [7:0] c, input bit sel, input bit expW,
                          input logic [15:0] expA, input logic [3:0] expD, input logic [15:0] expC);
        @(negedge clock);
        charIn = c;
        charValid = 1'b1;
        @(posedge clock);
        #1;
        chk({tag, ".wren"}, sel ? pmWrenS : pmWrenA, expW);
        if (expW) begin
            chk({tag, ".addr"}, sel ? pmAddressS : pmAddressA, expA);
            chk({tag, ".data"}, sel ? pmDataS : pmDataA, expD);
        end
        chk({tag, ".count"}, sel ? instrCountS : instrCountA, expC);
        @(posedge clock);
        #1;
        chk({tag, ".held"}, sel ? pmWrenS : pmWrenA, 1'b0);
        @(negedge clock);
        charValid = 1'b0;
    endtask

    task automatic finishLoad(input string tag, input logic [15:0] haltAddr);
        @(negedge clock);
        loadDone = 1'b1;
        @(posedge clock);
        #1;
        chk({tag, ".haltWren"}, pmWrenA, 1'b1);
        chk({tag, ".haltAddr"}, pmAddressA, haltAddr);
        chk({tag, ".haltData"}, pmDataA, 4'd0);
        chk({tag, ".doneEarly"}, doneA, 1'b0);
        @(posedge clock);
        #1;
        chk({tag, ".done"}, doneA, 1'b1);
        chk({tag, ".wrenOff"}, pmWrenA, 1'b0);
        chk({tag, ".count"}, instrCountA, haltAddr);
        @(negedge clock);
        loadDone = 1'b0;
    endtask

    initial begin
        doReset();
        #1;
        chk("rst.addr", pmAddressA, 16'd0);
        chk("rst.data", pmDataA, 4'd0);
        chk("rst.wren", pmWrenA, 1'b0);
        chk("rst.done", doneA, 1'b0);
        chk("rst.count", instrCountA, 16'd0);
        chk("rst.error", errorA, 1'b0);
        chk("rst.code", errCodeA, 2'd0);

        strobe("p1", 8'h2B, 1'b0, 1'b1, 16'd0, 4'd3, 16'd1);
        strobe("p2", 8'h3E, 1'b0, 1'b1, 16'd1, 4'd1, 16'd2);
        strobe("p3", 8'h2E, 1'b0, 1'b1, 16'd2, 4'd5, 16'd3);
        finishLoad("term1", 16'd3);
        strobe("afterDone", 8'h2B, 1'b0, 1'b0, 16'd0, 4'd0, 16'd3);
        chk("afterDone.done", doneA, 1'b1);

        doReset();
        strobe("cmtA", 8'h61, 1'b0, 1'b0, 16'd0, 4'd0, 16'd0);
        strobe("cmtSp", 8'h20, 1'b0, 1'b0, 16'd0, 4'd0, 16'd0);
        strobe("cmtPlus", 8'h2B, 1'b0, 1'b1, 16'd0, 4'd3, 16'd1);

        doReset();
        strobe("br1", 8'h5B, 1'b0, 1'b1, 16'd0, 4'd7, 16'd1);
        strobe("br2", 8'h2B, 1'b0, 1'b1, 16'd1, 4'd3, 16'd2);
        strobe("br3", 8'h5D, 1'b0, 1'b1, 16'd2, 4'd8, 16'd3);
        finishLoad("term2", 16'd3);

        doReset();
        strobe("unmatched", 8'h5D, 1'b0, 1'b0, 16'd0, 4'd0, 16'd0);
        chk("unmatched.error", errorA, 1'b1);
        chk("unmatched.code", errCodeA, 2'd1);

        doReset();
        strobe("open", 8'h5B, 1'b0, 1'b1, 16'd0, 4'd7, 16'd1);
        @(negedge clock);
        loadDone = 1'b1;
        @(posedge clock);
        #1;
        chk("unclosed.error", errorA, 1'b1);
        chk("unclosed.code", errCodeA, 2'd2);
        chk("unclosed.wren", pmWrenA, 1'b0);
        @(posedge clock);
        #1;
        chk("unclosed.done", doneA, 1'b0);
        chk("unclosed.noHalt", pmWrenA, 1'b0);
        @(negedge clock);
        loadDone = 1'b0;

        doReset();
        strobe("full0", 8'h2B, 1'b1, 1'b1, 16'd0, 4'd3, 16'd1);
        strobe("full1", 8'h2B, 1'b1, 1'b1, 16'd1, 4'd3, 16'd2);
        strobe("full2", 8'h2B, 1'b1, 1'b1, 16'd2, 4'd3, 16'd3);
        strobe("full3", 8'h2B, 1'b1, 1'b0, 16'd0, 4'd0, 16'd3);
        chk("full.error", errorS, 1'b1);
        chk("full.code", errCodeS, 2'd3);
        chk("full.bigOk", errorA, 1'b0);

        doReset();
        @(negedge clock);
        charIn = 8'h2D;
        charValid = 1'b1;
        loadDone = 1'b1;
        @(posedge clock);
        #1;
        chk("simul.wren", pmWrenA, 1'b1);
        chk("simul.addr", pmAddressA, 16'd0);
        chk("simul.data", pmDataA, 4'd4);
        chk("simul.count", instrCountA, 16'd1);
        @(posedge clock);
        #1;
        chk("simul.haltWren", pmWrenA, 1'b1);
        chk("simul.haltAddr", pmAddressA, 16'd1);
        chk("simul.haltData", pmDataA, 4'd0);
        chk("simul.doneEarly", doneA, 1'b0);
        @(posedge clock);
        #1;
        chk("simul.done", doneA, 1'b1);
        @(negedge clock);
        charValid = 1'b0;
        loadDone = 1'b0;

        doReset();
        strobe("pre", 8'h3C, 1'b0, 1'b1, 16'd0, 4'd2, 16'd1);
        @(negedge clock);
        charIn = 8'h2C;
        charValid = 1'b1;
        @(posedge clock);
        #1;
        chk("mid.wren", pmWrenA, 1'b1);
        chk("mid.addr", pmAddressA, 16'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("async.wren", pmWrenA, 1'b0);
        chk("async.addr", pmAddressA, 16'd0);
        chk("async.data", pmDataA, 4'd0);
        chk("async.count", instrCountA, 16'd0);
        charValid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        strobe("post", 8'h2B, 1'b0, 1'b1, 16'd0, 4'd3, 16'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
